// File: rtl/mbist_pkg.sv
// Shared types and March C- element table for the memory-BIST controller.
package mbist_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int unsigned ELEM_W     = 3;

    // Background selectors; expanded to the full data width in the controller.
    localparam logic BG_ZERO = 1'b0;
    localparam logic BG_ONE  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_CHECK = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic [ELEM_W-1:0] {
        ELEM_0 = 3'd0,
        ELEM_1 = 3'd1,
        ELEM_2 = 3'd2,
        ELEM_3 = 3'd3,
        ELEM_4 = 3'd4,
        ELEM_5 = 3'd5
    } elem_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        dir_e dir;
        logic has_read;
        logic has_write;
        logic rd_bg;
        logic wr_bg;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input elem_e e);
        elem_cfg_t c;
        case (e)
            ELEM_0:  c = '{dir: DIR_UP,   has_read: 1'b0, has_write: 1'b1, rd_bg: BG_ZERO, wr_bg: BG_ZERO};
            ELEM_1:  c = '{dir: DIR_UP,   has_read: 1'b1, has_write: 1'b1, rd_bg: BG_ZERO, wr_bg: BG_ONE};
            ELEM_2:  c = '{dir: DIR_UP,   has_read: 1'b1, has_write: 1'b1, rd_bg: BG_ONE,  wr_bg: BG_ZERO};
            ELEM_3:  c = '{dir: DIR_DOWN, has_read: 1'b1, has_write: 1'b1, rd_bg: BG_ZERO, wr_bg: BG_ONE};
            ELEM_4:  c = '{dir: DIR_DOWN, has_read: 1'b1, has_write: 1'b1, rd_bg: BG_ONE,  wr_bg: BG_ZERO};
            default: c = '{dir: DIR_UP,   has_read: 1'b1, has_write: 1'b0, rd_bg: BG_ZERO, wr_bg: BG_ZERO};
        endcase
        return c;
    endfunction

    // First operation performed at every address of an element.
    function automatic state_e first_op(input elem_e e);
        return elem_cfg(e).has_read ? ST_RD_ISSUE : ST_WR;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the March sequencer; direction is latched on load.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  dir_e              dir,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    dir_e dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            dir_q <= DIR_UP;
        end else if (load) begin
            addr  <= (dir == DIR_DOWN) ? '1 : '0;
            dir_q <= dir;
        end else if (inc) begin
            addr  <= (dir_q == DIR_UP) ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
        end
    end

    always_comb begin
        last_c = (dir_q == DIR_UP) ? (addr == '1) : (addr == '0);
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory-BIST controller with first-mismatch capture.
// Optional MBIST_STOP_ON_FAIL_EN: end the run at the first read mismatch.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramin,
    output logic              rwbar,
    output logic              cs,
    input  logic [DATA_W-1:0] ramout,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ELEM_W-1:0] fail_elem,
    output logic [DATA_W-1:0] fail_data
);

`ifdef MBIST_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    state_e            state_q, state_d;
    elem_e             elem_q, elem_d;
    logic              ag_load, ag_inc;
    dir_e              ag_dir;
    logic [ADDR_W-1:0] addr;
    logic              addr_last_c;
    logic              diag_clr, diag_cap;

    elem_cfg_t         cfg_c;
    logic [DATA_W-1:0] exp_c;
    logic              mismatch_c;
    elem_e             adv_elem_c;
    state_e            adv_state_c;
    dir_e              adv_dir_c;
    logic              adv_done_c;

    mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ag_load),
        .inc    (ag_inc),
        .dir    (ag_dir),
        .addr   (addr),
        .last_c (addr_last_c)
    );

    assign ramaddr = addr;

    // Current element decode and read compare.
    always_comb begin
        cfg_c      = elem_cfg(elem_q);
        exp_c      = {DATA_W{cfg_c.rd_bg}};
        mismatch_c = (state_q == ST_RD_CHECK) && (ramout != exp_c);
    end

    // Where the sequencer goes after the last operation of the current element.
    always_comb begin
        adv_done_c  = (elem_q == ELEM_5);
        adv_elem_c  = adv_done_c ? elem_q : elem_e'(3'(elem_q) + 3'd1);
        adv_state_c = adv_done_c ? ST_DONE : first_op(adv_elem_c);
        adv_dir_c   = adv_done_c ? DIR_UP : elem_cfg(adv_elem_c).dir;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            elem_q  <= ELEM_0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        ag_load  = 1'b0;
        ag_inc   = 1'b0;
        ag_dir   = DIR_UP;
        diag_clr = 1'b0;
        diag_cap = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = first_op(ELEM_0);
                    elem_d   = ELEM_0;
                    ag_load  = 1'b1;
                    ag_dir   = elem_cfg(ELEM_0).dir;
                    diag_clr = 1'b1;
                end
            end
            ST_WR: begin
                if (addr_last_c) begin
                    state_d = adv_state_c;
                    elem_d  = adv_elem_c;
                    ag_load = 1'b1;
                    ag_dir  = adv_dir_c;
                end else begin
                    ag_inc  = 1'b1;
                    state_d = first_op(elem_q);
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CHECK;
            end
            ST_RD_CHECK: begin
                diag_cap = mismatch_c && !fail;
                if (STOP_ON_FAIL && mismatch_c) begin
                    // Reloading the counter parks the address bus at 0 in DONE.
                    state_d = ST_DONE;
                    ag_load = 1'b1;
                    ag_dir  = DIR_UP;
                end else if (cfg_c.has_write) begin
                    state_d = ST_WR;
                end else if (addr_last_c) begin
                    state_d = adv_state_c;
                    elem_d  = adv_elem_c;
                    ag_load = 1'b1;
                    ag_dir  = adv_dir_c;
                end else begin
                    ag_inc  = 1'b1;
                    state_d = ST_RD_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM controls and status are registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs    <= 1'b0;
            rwbar <= 1'b1;
            ramin <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            cs    <= (state_d == ST_WR) || (state_d == ST_RD_ISSUE) || (state_d == ST_RD_CHECK);
            rwbar <= (state_d != ST_WR);
            ramin <= (state_d == ST_WR) ? {DATA_W{elem_cfg(elem_d).wr_bg}} : '0;
            busy  <= (state_d == ST_WR) || (state_d == ST_RD_ISSUE) || (state_d == ST_RD_CHECK);
            done  <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
        end else if (diag_clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
        end else if (diag_cap) begin
            fail      <= 1'b1;
            fail_addr <= addr;
            fail_elem <= 3'(elem_q);
            fail_data <= ramout;
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: SRAM model with an injectable stuck-at bit and a March C- reference model.
module tb_mbist_march_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramin;
    logic          rwbar;
    logic          cs;
    logic [DW-1:0] ramout;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data;

    int errors = 0;
    int checks = 0;

    // Fault injection controls for the SRAM model
    bit f_en = 1'b0;
    int f_addr = 0;
    int f_bit = 0;
    bit f_val = 1'b0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q;

    always #5 clk = ~clk;

    mbist_march_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ramaddr   (ramaddr),
        .ramin     (ramin),
        .rwbar     (rwbar),
        .cs        (cs),
        .ramout    (ramout),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_data (fail_data)
    );

    // Synchronous-read SRAM; output gated by cs && rwbar.
    always @(posedge clk) begin
        logic [DW-1:0] rd;
        if (cs) begin
            if (!rwbar) begin
                mem[ramaddr] <= ramin;
            end else begin
                rd = mem[ramaddr];
                if (f_en && int'(ramaddr) == f_addr) rd[f_bit] = f_val;
                q <= rd;
            end
        end
    end
    assign ramout = (cs && rwbar) ? q : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain March C- walk: reads cost 2 cycles, writes 1; returns first mismatch and its check cycle.
    task automatic march_model(output bit found, output int fa, output int fe, output int fd, output int fcyc);
        int rd_exp [6] = '{-1, 0, 255, 0, 255, 0};
        int wr_val [6] = '{0, 255, 0, 255, 0, -1};
        int m [DEPTH];
        int cyc;
        cyc = 0; found = 1'b0; fa = 0; fe = 0; fd = 0; fcyc = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int a;
                a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
                if (rd_exp[e] >= 0) begin
                    int v;
                    cyc += 2;
                    v = m[a];
                    if (f_en && a == f_addr) begin
                        if (f_val) v = v | (1 << f_bit);
                        else       v = v & ~(1 << f_bit);
                    end
                    if (v != rd_exp[e] && !found) begin
                        found = 1'b1; fa = a; fe = e; fd = v; fcyc = cyc;
                    end
                end
                if (wr_val[e] >= 0) begin
                    cyc += 1;
                    m[a] = wr_val[e];
                end
            end
        end
    endtask

    task automatic run_test(input string tag, input int repulse_at, input bit chk_order);
        bit found;
        int fa, fe, fd, fcyc;
        int exp_done, exp_cs, cs_cnt, busy_cnt, done_cyc, a449, a833;
        bit stop_mode;
`ifdef MBIST_STOP_ON_FAIL_EN
        stop_mode = 1'b1;
`else
        stop_mode = 1'b0;
`endif
        march_model(found, fa, fe, fd, fcyc);
        exp_done = (stop_mode && found) ? fcyc + 1 : 961;
        exp_cs   = exp_done - 1;
        cs_cnt = 0; busy_cnt = 0; done_cyc = 0; a449 = -1; a833 = -1;

        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 1500; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_c1_busy"}, 32'(busy), 32'd1);
                check({tag, "_c1_done"}, 32'(done), 32'd0);
                check({tag, "_c1_fail"}, 32'(fail), 32'd0);
            end
            if (cs) cs_cnt++;
            if (busy) busy_cnt++;
            if (k == 449) a449 = int'(ramaddr);
            if (k == 833) a833 = int'(ramaddr);
            start = (k == repulse_at);
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check({tag, "_cs_cycles"}, 32'(cs_cnt), 32'(exp_cs));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cs));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'(found));
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'(fa));
        check({tag, "_fail_elem"}, 32'(fail_elem), 32'(fe));
        check({tag, "_fail_data"}, 32'(fail_data), 32'(fd));
        if (chk_order && !(stop_mode && found)) begin
            check({tag, "_e3_first_addr"}, 32'(a449), 32'd63);
            check({tag, "_e5_first_addr"}, 32'(a833), 32'd0);
        end
        repeat (3) @(negedge clk);
        check({tag, "_idle_cs"}, 32'(cs), 32'd0);
        check({tag, "_idle_addr"}, 32'(ramaddr), 32'd0);
        check({tag, "_done_held"}, 32'(done), 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(cs), 32'd0);
        check("rst_rwbar", 32'(rwbar), 32'd1);
        check("rst_addr", 32'(ramaddr), 32'd0);
        check("rst_ramin", 32'(ramin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_diag", 32'({fail_addr, fail_elem, fail_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free run with an ignored start re-pulse at cycle 50
        f_en = 1'b0;
        run_test("clean", 50, 1'b1);

        // Directed stuck-at-1 on bit 3 of address 17, started from DONE
        f_en = 1'b1; f_addr = 17; f_bit = 3; f_val = 1'b1;
        run_test("sa1_a17b3", 0, 1'b0);

        // Random stuck-at faults, each restarted from DONE with fail set
        for (int r = 0; r < 4; r++) begin
            f_en = 1'b1;
            f_addr = int'($urandom_range(DEPTH - 1, 0));
            f_bit = int'($urandom_range(DW - 1, 0));
            f_val = 1'($urandom_range(1, 0));
            run_test($sformatf("rand%0d", r), 0, 1'b1);
        end

        // Mid-run reset at cycle 300, released at cycle 305
        f_en = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k < 300; k++) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 300; k < 305; k++) begin
            #1;
            check($sformatf("rst_mid_cs_%0d", k), 32'(cs), 32'd0);
            check($sformatf("rst_mid_busy_%0d", k), 32'(busy), 32'd0);
            check($sformatf("rst_mid_done_%0d", k), 32'(done), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_test("post_reset", 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
